// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: 8N1 frames by default, 8E1 when UART_TX_PARITY_EN is defined.
// Bytes written by the wrapper queue in a DEPTH-entry FIFO and are sent back to back on TxD.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     TxD
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [15:0]      LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               full_q, full_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         mem_q [DEPTH];
  logic               wr_acc;
  logic               pop;
  logic               bit_end;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  always_comb begin
    wr_acc   = wr_en && !full_q;
    pop      = 1'b0;
    bit_end  = (cnt_q == LAST_CNT);
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    rd_ptr_d = rd_ptr_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q != '0) pop = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (bit_end) begin
          cnt_d = '0;
          if (level_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (pop) begin
      state_d  = START;
      cnt_d    = '0;
      txd_d    = 1'b0;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({wr_acc, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d = (level_d == DEPTH_LVL);
    // A write against a full FIFO is lost even if a pop frees a slot this cycle.
    ovf_d  = ovf_q | (wr_en & full_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign TxD      = txd_q;
  assign level    = level_q;
  assign full     = full_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven frames, hand-written corner cases,
// and random write traffic compared every cycle against a frame-position reference model.
module tb_uart_tx_fifo;

  localparam int C     = 4;
  localparam int D     = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR   = 1'b1;
`else
  localparam bit PAR   = 1'b0;
`endif
  localparam int NBITS = PAR ? 11 : 10;
  localparam int FRAME = NBITS * C;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic [3:0] level;
  logic       busy;
  logic       overflow;
  logic       TxD;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .TxD      (TxD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    logic       par;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] d);
    @(negedge clk);
    wr_en   = we;
    wr_data = d;
  endtask

  // Reference model: a byte queue plus the position inside the frame currently on the line.
  logic       s_rst = 1'b0;
  logic       s_we  = 1'b0;
  logic [7:0] s_wd  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_active = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q [$];

  always @(posedge clk) begin
    s_rst <= reset;
    s_we  <= wr_en;
    s_wd  <= wr_data;
  end

  function automatic logic bitAt(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (PAR && idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic modelStep();
    int pre;
    if (s_rst === 1'b1) begin
      m_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_valid  = 1'b1;
      return;
    end
    if (!m_valid) return;
    pre = m_q.size();
    if (m_active && m_pos != FRAME - 1) begin
      m_pos++;
    end else if (pre != 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end else begin
      m_active = 1'b0;
    end
    if (s_we === 1'b1) begin
      if (pre < D) m_q.push_back(s_wd);
      else m_ovf = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_v;
    int sz;
    modelStep();
    if (m_valid) begin
      sz = m_q.size();
      exp_v = {m_active ? bitAt(m_cur, m_pos / C) : 1'b1,
               m_active || sz != 0, sz == D, m_ovf, 4'(sz)};
      checkOutput("model_txd_busy_full_ovf_level",
                  {24'd0, TxD, busy, full, overflow, level}, {24'd0, exp_v});
    end
  end

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic checkFrame(input vec_t v);
    logic e;
    applyStimulus(1'b1, v.data);
    applyStimulus(1'b0, 8'h00);
    for (int b = 0; b < NBITS; b++) begin
      if (b < 9 || (!PAR && b == 9)) e = v.bits[b];
      else if (b == 9) e = v.par;
      else e = 1'b1;
      for (int k = 0; k < C; k++) begin
        @(negedge clk);
        checkOutput($sformatf("frame_%02h_bit%0d", v.data, b), {31'd0, TxD}, {31'd0, e});
      end
    end
    checkOutput($sformatf("frame_%02h_busy_last", v.data), {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput($sformatf("frame_%02h_busy_end", v.data), {31'd0, busy}, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lows;
    int rate;
    logic we;

    vecs[0] = '{8'h55, 10'b1010101010, 1'b0};
    vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
    vecs[2] = '{8'h03, 10'b1000000110, 1'b0};
    vecs[3] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[4] = '{8'h80, 10'b1100000000, 1'b1};

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_txd", {31'd0, TxD}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_level", {28'd0, level}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_full", {31'd0, full}, 32'd0);

    for (int i = 0; i < 5; i++) checkFrame(vecs[i]);

    // Burst into a busy transmitter until the FIFO overflows.
    applyStimulus(1'b1, 8'hA0);
    applyStimulus(1'b0, 8'h00);
    repeat (2) applyStimulus(1'b0, 8'h00);
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 8'(8'hA0 + i));
    applyStimulus(1'b0, 8'h00);
    checkOutput("burst_level", {28'd0, level}, 32'd8);
    checkOutput("burst_full", {31'd0, full}, 32'd1);
    checkOutput("burst_overflow", {31'd0, overflow}, 32'd1);
    waitIdle(9 * FRAME + 50, "burst_drain");
    checkOutput("burst_drain_level", {28'd0, level}, 32'd0);

    // Abort mid-frame with reset.
    doReset();
    applyStimulus(1'b1, 8'h3C);
    applyStimulus(1'b0, 8'h00);
    repeat (18) @(negedge clk);
    checkOutput("abort_bit3_before_reset", {31'd0, TxD}, 32'd1);
    checkOutput("abort_busy_before_reset", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_txd", {31'd0, TxD}, 32'd1);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_level", {28'd0, level}, 32'd0);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    checkOutput("abort_no_frame", lows, 32'd0);

    // Write against a full FIFO on the exact cycle the head is popped.
    applyStimulus(1'b1, 8'h10);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    applyStimulus(1'b0, 8'h00);
    repeat (FRAME - 9) applyStimulus(1'b0, 8'h00);
    checkOutput("popcycle_full_before", {31'd0, full}, 32'd1);
    checkOutput("popcycle_level_before", {28'd0, level}, 32'd8);
    checkOutput("popcycle_ovf_before", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b1, 8'hEE);
    applyStimulus(1'b0, 8'h00);
    checkOutput("popcycle_level", {28'd0, level}, 32'd7);
    checkOutput("popcycle_overflow", {31'd0, overflow}, 32'd1);
    checkOutput("popcycle_full", {31'd0, full}, 32'd0);
    waitIdle(9 * FRAME + 50, "popcycle_drain");

    // Random traffic with varying write density; the model checks every cycle.
    doReset();
    rate = 5;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 400 == 0) rate = $urandom_range(1, 12);
      we = ($urandom_range(0, 99) < rate);
      applyStimulus(we, 8'($urandom));
    end
    applyStimulus(1'b0, 8'h00);
    waitIdle((D + 1) * FRAME + 50, "random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
